riscv_lsu: RTL and testbench

Load/store unit for the multi-cycle RISC-V core. Sits between the control/datapath and the shared instruction/data memory, which has a word-per-entry array, a registered read, and a byte-enabled write. It takes one load or store request at a time and does three things: aligns store data and generates per-byte write enables; waits out the memory's registered read latency; and extracts and sign/zero-extends load data. Misaligned and illegal accesses are flagged without touching memory.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/riscv_load_extract.sv | 32 +++
 rtl/riscv_lsu.sv | 142 ++++++++++++++
 tb/tb_riscv_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store width codes and LSU state encoding.
// Pure package with no logic of its own.
// Imported by the LSU and its load-extraction helper.
package riscv_pkg;

  // funct3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_DONE,
    ST_ERR
  } lsu_state_t;

  // Encodings with no load/store meaning, or unsigned variants used on a store
  function automatic logic req_illegal(input logic st, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3 == F3_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_load_extract.sv
// Picks the addressed byte/half/word out of a memory word and extends it.
// Purely combinational; no state.
// Shared by the LSU response path and any later cache read path.
module riscv_load_extract
  import riscv_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed field, then extend according to the width code
  always_comb begin
    shifted  = read_data >> {lane, 3'b000};
    byte_val = shifted[7:0];
    half_val = lane[1] ? read_data[31:16] : read_data[15:0];
    value    = read_data;
    case (funct3)
      F3_B:    value = {{24{byte_val[7]}}, byte_val};
      F3_BU:   value = {24'h0, byte_val};
      F3_H:    value = {{16{half_val[15]}}, half_val};
      F3_HU:   value = {16'h0, half_val};
      default: value = read_data;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, byte-lane stores, extended loads.
// Store done in cycle 2, load done in cycle 3, rejected request flagged in cycle 1.
// start is only looked at in IDLE; requests arriving while busy are dropped.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        WRbe,
  output logic              DMwrite,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
);

  lsu_state_t  state;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic [31:0] ext_val;

  logic [1:0]  lane_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        reject_in;

  riscv_load_extract u_extract (
    .read_data (ReadData),
    .lane      (lane_q),
    .funct3    (f3_q),
    .value     (ext_val)
  );

  // Store lane enables, replicated write data and request legality from the raw request
  always_comb begin
    lane_in   = addr_in[1:0];
    reject_in = req_illegal(is_store, funct3) || req_misaligned(funct3, lane_in);
    be_in     = 4'b1111;
    wdata_in  = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << lane_in;
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = lane_in[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
  end

  // Request FSM; every output is a register so nothing follows start combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
      store_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      DMwrite   <= 1'b0;
      WRbe      <= 4'b0000;
      addr      <= '0;
      WriteData <= 32'h0;
      load_data <= 32'h0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      DMwrite <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (reject_in) begin
              // Rejected requests never reach the memory interface
              state <= ST_ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= ST_ACCESS;
              lane_q  <= lane_in;
              f3_q    <= funct3;
              store_q <= is_store;
              addr    <= {addr_in[ADDR_W-1:2], 2'b00};
              if (is_store) begin
                WRbe      <= be_in;
                WriteData <= wdata_in;
                DMwrite   <= 1'b1;
              end else begin
                WRbe <= 4'b0000;
              end
            end
          end
        end
        ST_ACCESS: begin
          WRbe <= 4'b0000;
          if (store_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // ReadData now reflects the word addressed during ACCESS
          load_data <= ext_val;
          state     <= ST_DONE;
          done      <= 1'b1;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed test-plan cases followed by random requests.
// Memory is a word array with registered read and byte-enabled write.
// Expected results come from a byte-addressed reference memory.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr_in;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] addr;
  logic [3:0]  WRbe;
  logic        DMwrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [31:0] mem     [0:1023];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] exp_ld;

  riscv_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr_in    (addr_in),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .addr       (addr),
    .WRbe       (WRbe),
    .DMwrite    (DMwrite),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  // Instruction/data memory: registered read, byte-enabled write
  always @(posedge clk) begin
    ReadData <= mem[addr[11:2]];
    if (DMwrite) begin
      for (int b = 0; b < 4; b++)
        if (WRbe[b]) mem[addr[11:2]][8*b +: 8] <= WriteData[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
    if (st && f3 >= 3'd4) return 1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(a + i) % 4096]) << (8 * i));
    if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 1);
    return v;
  endfunction

  // One request from the IDLE cycle through to the next IDLE cycle
  task automatic req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input bit hold);
    bit          bad = is_bad(st, f3, a);
    int          sz  = size_of(f3);
    int          ln  = int'(a % 4);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    start = 1'b1; is_store = st; funct3 = f3; addr_in = a; store_data = sd;
    step();
    if (!hold) start = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    if (bad) begin
      chk("err_done", 32'(done), 32'd1);
      chk("err_flag", 32'(err), 32'd1);
      chk("err_nowrite", 32'(DMwrite), 32'd0);
      chk("err_ld_kept", load_data, exp_ld);
      start = 1'b0;
      step();
      chk("err_idle_busy", 32'(busy), 32'd0);
      chk("err_idle_done", 32'(done), 32'd0);
      return;
    end
    chk("addr_c1", addr, a & 32'hFFFF_FFFC);
    chk("dmwrite_c1", 32'(DMwrite), 32'(st));
    chk("done_c1", 32'(done), 32'd0);
    if (st) begin
      ebe = 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= ln && i < ln + sz) ebe[i] = 1'b1;
      ewd = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
      chk("wrbe_c1", 32'(WRbe), 32'(ebe));
      chk("wdata_c1", WriteData, ewd);
      for (int i = 0; i < sz; i++) ref_mem[(a + i) % 4096] = sd[8*i +: 8];
      step();
      chk("st_done", 32'(done), 32'd1);
      chk("st_err", 32'(err), 32'd0);
      chk("st_dmwrite_off", 32'(DMwrite), 32'd0);
      start = 1'b0;
      step();
      chk("st_idle_busy", 32'(busy), 32'd0);
    end else begin
      chk("ld_wrbe", 32'(WRbe), 32'd0);
      step();
      chk("ld_c2_done", 32'(done), 32'd0);
      chk("ld_c2_busy", 32'(busy), 32'd1);
      step();
      exp_ld = model_load(f3, a);
      chk("ld_done", 32'(done), 32'd1);
      chk("ld_err", 32'(err), 32'd0);
      chk("ld_data", load_data, exp_ld);
      start = 1'b0;
      step();
      chk("ld_idle_busy", 32'(busy), 32'd0);
      chk("ld_idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          mism;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr_in = 32'h0; store_data = 32'h0; exp_ld = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      w = (i == 3) ? 32'h4020D3B3 : $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dmwrite", 32'(DMwrite), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_addr", addr, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Loads from the known word 0x4020D3B3
    req(0, 3'b000, 32'h0C, 32'h0, 0);
    chk("lb_value", load_data, 32'hFFFFFFB3);
    req(0, 3'b100, 32'h0C, 32'h0, 0);
    chk("lbu_value", load_data, 32'h000000B3);
    req(0, 3'b001, 32'h0C, 32'h0, 0);
    chk("lh_value", load_data, 32'hFFFFD3B3);
    req(0, 3'b101, 32'h0E, 32'h0, 0);
    chk("lhu_value", load_data, 32'h00004020);

    // Byte store into the top lane, then read the word back
    w = {ref_mem[32'h207], ref_mem[32'h206], ref_mem[32'h205], ref_mem[32'h204]};
    req(1, 3'b000, 32'h207, 32'h123456AB, 0);
    req(0, 3'b010, 32'h204, 32'h0, 0);
    chk("sb_word", load_data, {8'hAB, w[23:0]});

    // Back-to-back stores
    req(1, 3'b001, 32'h212, $urandom, 0);
    req(1, 3'b010, 32'h220, $urandom, 0);

    // Rejected requests
    req(0, 3'b010, 32'h06, 32'h0, 0);
    req(1, 3'b001, 32'h03, 32'h5555, 0);
    req(1, 3'b100, 32'h40, 32'h77, 0);

    // Reset during the write cycle of a word store
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr_in = 32'h230; store_data = 32'hDEADBEEF;
    step();
    start = 1'b0;
    chk("abort_dmwrite_c1", 32'(DMwrite), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_ld = 32'h0;
    chk("abort_dmwrite", 32'(DMwrite), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wrbe", 32'(WRbe), 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_wdata", WriteData, 32'd0);
    chk("abort_ld", load_data, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    req(0, 3'b010, 32'h230, 32'h0, 0);

    // start held high for a whole load
    req(0, 3'b000, 32'h101, 32'h0, 1);

    // Random mix
    for (int n = 0; n < 300; n++)
      req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 4095)), $urandom, 1'($urandom_range(0, 3) == 0));

    mism = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
